// File: rtl/regfile_wr_arbiter_if.sv
// Requester/register-file bus of the register-file write-port arbiter.
// The slave modport is the arbiter side; the master modport is the requester/regfile side.
interface regfile_wr_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [3*NREQ-1:0]  req_addr;
   logic [DW*NREQ-1:0] req_data;
   logic [NREQ-1:0]    req_lock;
   logic [NREQ-1:0]    req_ready;
   logic [7:0]         reg_we;
   logic [DW-1:0]      reg_wdata;
   logic [IDW-1:0]     grant_id;
   logic               locked;

   modport master (
      output req_valid, req_addr, req_data, req_lock,
      input  req_ready, reg_we, reg_wdata, grant_id, locked
   );

   modport slave (
      input  req_valid, req_addr, req_data, req_lock,
      output req_ready, reg_we, reg_wdata, grant_id, locked
   );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter with an optional ownership lock for the single write port of an
// 8-entry register file; registers a one-hot write enable and the data of the winner.
module regfile_wr_arbiter #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_wr_arbiter_if.slave  bus
);

   typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

   localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
   localparam logic [IDW-1:0] LAST_Q = IDW'(NREQ - 1);

   state_t          state_q;
   logic [IDW-1:0]  rr_ptr_q;
   logic [IDW-1:0]  owner_q;
   logic [7:0]      reg_we_q;
   logic [DW-1:0]   reg_wdata_q;
   logic [IDW-1:0]  grant_id_q;
   logic            locked_q;

   logic [2:0]      addr_a [NREQ];
   logic [DW-1:0]   data_a [NREQ];
   logic [IDW:0]    sum_s;
   logic            found_s;
   logic [IDW-1:0]  win_s;
   logic [IDW-1:0]  sel_s;
   logic            sel_ok_s;
   logic [NREQ-1:0] ready_s;
   logic            accept_s;
   logic [IDW-1:0]  rr_ptr_d;

   function automatic logic [7:0] addr_to_we(input logic [2:0] addr);
      addr_to_we = 8'd1 << addr;
   endfunction

   // Unpack the flattened per-requester address and data buses.
   always_comb begin
      for (int k = 0; k < NREQ; k++) begin
         addr_a[k] = bus.req_addr[3*k +: 3];
         data_a[k] = bus.req_data[DW*k +: DW];
      end
   end

   // First valid requester at or after rr_ptr, wrapping at NREQ-1.
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      sum_s   = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum_s = {1'b0, rr_ptr_q} + (IDW+1)'(i);
         if (sum_s >= NREQ_W) begin
            sum_s = sum_s - NREQ_W;
         end else begin
            sum_s = sum_s;
         end
         if (!found_s && bus.req_valid[sum_s[IDW-1:0]]) begin
            found_s = 1'b1;
            win_s   = sum_s[IDW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   // A lock owner keeps ready even while it is not valid, stalling everyone else.
   always_comb begin
      sel_s    = win_s;
      sel_ok_s = found_s;
      ready_s  = '0;
      if (state_q == ST_LOCKED) begin
         sel_s    = owner_q;
         sel_ok_s = 1'b1;
      end else begin
         sel_s    = win_s;
         sel_ok_s = found_s;
      end
      if (sel_ok_s && !rst) begin
         ready_s[sel_s] = 1'b1;
      end else begin
         ready_s = '0;
      end
      accept_s = ready_s[sel_s] & bus.req_valid[sel_s];
      rr_ptr_d = (sel_s == LAST_Q) ? '0 : sel_s + IDW'(1);
   end

   // Arbitration state, lock ownership and the registered write port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         reg_we_q    <= 8'd0;
         reg_wdata_q <= '0;
         grant_id_q  <= '0;
         locked_q    <= 1'b0;
      end else if (accept_s) begin
         reg_we_q    <= addr_to_we(addr_a[sel_s]);
         reg_wdata_q <= data_a[sel_s];
         grant_id_q  <= sel_s;
         rr_ptr_q    <= rr_ptr_d;
         case (state_q)
            ST_IDLE: begin
               if (bus.req_lock[sel_s]) begin
                  state_q  <= ST_LOCKED;
                  owner_q  <= sel_s;
                  locked_q <= 1'b1;
               end else begin
                  state_q  <= ST_IDLE;
                  locked_q <= 1'b0;
               end
            end
            ST_LOCKED: begin
               if (!bus.req_lock[sel_s]) begin
                  state_q  <= ST_IDLE;
                  locked_q <= 1'b0;
               end else begin
                  state_q  <= ST_LOCKED;
                  locked_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               locked_q <= 1'b0;
            end
         endcase
      end else begin
         reg_we_q <= 8'd0;
      end
   end

   assign bus.req_ready = ready_s;
   assign bus.reg_we    = reg_we_q;
   assign bus.reg_wdata = reg_wdata_q;
   assign bus.grant_id  = grant_id_q;
   assign bus.locked    = locked_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed and randomized checks of regfile_wr_arbiter against a queue-free
// behavioural model of round-robin grants, locking and the one-cycle write port.
module tb_regfile_wr_arbiter;
   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int IDW  = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regfile_wr_arbiter_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) rif ();

   regfile_wr_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (rif.slave)
   );

   int checks = 0;
   int errors = 0;

   logic [3:0] v;
   logic [3:0] lk;
   logic [2:0] a [4];
   logic [7:0] d [4];

   int         m_rr;
   int         m_own;
   bit         m_lk;
   logic [7:0] e_we;
   logic [7:0] e_wd;
   int         e_gid;
   int         last_acc;
   int         n1;
   int         budget;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      rif.req_valid = v;
      rif.req_lock  = lk;
      for (int k = 0; k < NREQ; k++) begin
         rif.req_addr[3*k +: 3] = a[k];
         rif.req_data[8*k +: 8] = d[k];
      end
   endtask

   task automatic model_reset();
      m_rr  = 0;
      m_own = 0;
      m_lk  = 1'b0;
      e_we  = 8'd0;
      e_wd  = 8'd0;
      e_gid = 0;
   endtask

   // Requester the model expects to hold ready: the lock owner, else first valid from m_rr.
   function automatic int m_pick();
      if (m_lk) return m_own;
      for (int i = 0; i < NREQ; i++) begin
         if (v[(m_rr + i) % NREQ]) return (m_rr + i) % NREQ;
      end
      return -1;
   endfunction

   task automatic check_out();
      chk("reg_we",    32'(rif.reg_we),    32'(e_we));
      chk("reg_wdata", 32'(rif.reg_wdata), 32'(e_wd));
      chk("grant_id",  32'(rif.grant_id),  32'(e_gid));
      chk("locked",    32'(rif.locked),    32'(m_lk));
      chk("we_onehot0", 32'($onehot0(rif.reg_we)), 32'd1);
   endtask

   task automatic cycle();
      int         w;
      logic [3:0] er;
      drive();
      #1;
      w  = m_pick();
      er = (w >= 0) ? 4'(1 << w) : 4'd0;
      chk("req_ready", 32'(rif.req_ready), 32'(er));
      @(posedge clk);
      last_acc = -1;
      if (w >= 0 && v[w]) begin
         last_acc = w;
         e_we  = 8'(1 << a[w]);
         e_wd  = d[w];
         e_gid = w;
         if (!m_lk) begin
            m_rr = (w + 1) % NREQ;
            if (lk[w]) begin
               m_lk  = 1'b1;
               m_own = w;
            end
         end else if (!lk[w]) begin
            m_lk = 1'b0;
            m_rr = (w + 1) % NREQ;
         end
      end else begin
         e_we = 8'd0;
      end
      #1;
      check_out();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset: all valid, nothing may be ready while rst is high.
      rst = 1'b1;
      v   = 4'b1111;
      lk  = 4'b0000;
      for (int k = 0; k < NREQ; k++) begin
         a[k] = 3'(k);
         d[k] = 8'hA0 + 8'(k);
      end
      drive();
      #2;
      chk("rst_ready",  32'(rif.req_ready), 32'd0);
      chk("rst_we",     32'(rif.reg_we),    32'd0);
      chk("rst_wdata",  32'(rif.reg_wdata), 32'd0);
      chk("rst_gid",    32'(rif.grant_id),  32'd0);
      chk("rst_locked", 32'(rif.locked),    32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready_hold", 32'(rif.req_ready), 32'd0);
      rst = 1'b0;
      model_reset();
      cycle();
      chk("first_grant", 32'(last_acc), 32'd0);

      // Round-robin with all four valid.
      for (int i = 0; i < 8; i++) begin
         cycle();
         chk("rr_gid", 32'(rif.grant_id), 32'((i + 1) % NREQ));
         chk("rr_we",  32'(rif.reg_we),   32'(1 << ((i + 1) % NREQ)));
      end

      // Full address decode from requester 2 alone.
      v = 4'b0100;
      for (int i = 0; i < 8; i++) begin
         a[2] = 3'(i);
         d[2] = 8'h10 + 8'(i);
         cycle();
         chk("dec_we",    32'(rif.reg_we),    32'(1 << i));
         chk("dec_wdata", 32'(rif.reg_wdata), 32'(8'h10 + 8'(i)));
      end

      // Lock by requester 1 with 0 and 3 competing, then again with 2 valid and idle gaps.
      for (int pass = 0; pass < 2; pass++) begin
         n1     = 0;
         budget = 0;
         while (n1 < 3 && budget < 30) begin
            v  = (pass == 0) ? 4'b1011 : 4'b1111;
            lk = 4'b0000;
            lk[1] = (n1 < 2);
            for (int k = 0; k < NREQ; k++) begin
               a[k] = 3'($urandom_range(0, 7));
               d[k] = 8'($urandom);
            end
            if (pass == 1 && n1 == 1 && budget < 40) begin
               v[1] = 1'b0;
               for (int g = 0; g < 2; g++) begin
                  cycle();
                  chk("lock_stall", 32'(last_acc), 32'hFFFF_FFFF);
               end
               v[1] = 1'b1;
            end
            cycle();
            if (last_acc == 1) begin
               n1++;
               chk("lock_state", 32'(rif.locked), 32'(n1 < 3));
            end
            budget++;
         end
         chk("lock_done", 32'(n1), 32'd3);
         lk = 4'b0000;
         cycle();
         chk("post_unlock", 32'(last_acc), (pass == 0) ? 32'd3 : 32'd2);
      end

      // Wrap from rr_ptr=3 with only 0 and 3 valid.
      v = 4'b0100;
      cycle();
      v = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("wrap_grant", 32'(last_acc), (i == 1) ? 32'd0 : 32'd3);
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 60; i++) begin
         v  = 4'($urandom);
         lk = 4'($urandom) & 4'($urandom);
         for (int k = 0; k < NREQ; k++) begin
            a[k] = 3'($urandom_range(0, 7));
            d[k] = 8'($urandom);
         end
         cycle();
      end

      // Asynchronous reset during a locked burst.
      v  = 4'b0100;
      lk = 4'b0100;
      cycle();
      cycle();
      chk("pre_rst_locked", 32'(rif.locked), 32'd1);
      v = 4'b1111;
      drive();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_we",     32'(rif.reg_we),    32'd0);
      chk("arst_locked", 32'(rif.locked),    32'd0);
      chk("arst_ready",  32'(rif.req_ready), 32'd0);
      chk("arst_wdata",  32'(rif.reg_wdata), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      lk  = 4'b0000;
      cycle();
      chk("arst_first_grant", 32'(last_acc), 32'd0);
      cycle();
      chk("arst_second_grant", 32'(last_acc), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
